// File: rtl/lane_collector_pkg.sv
// lane_collector shared types
// state encoding and timer width helper
package lane_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  function automatic int cnt_w(input int t);
    if (t <= 2) return 1;
    return $clog2(t);
  endfunction

endpackage

// File: rtl/lane_collector_timer.sv
// lane_collector timeout counter
// counts collect cycles up to TIMEOUT-1
module lane_collector_timer
  import lane_collector_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == LAST);

  // count while enabled, hold at the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lane_collector.sv
// lane_collector top
// gathers one bit per lane into a word
module lane_collector
  import lane_collector_pkg::*;
#(
  parameter int W       = 6,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lane_vld,
  input  logic [W-1:0] lane_bit,
  input  logic         out_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic [W-1:0] out_missing,
  output logic         out_timeout,
  output logic         busy,
  output logic         err_dup
);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] seen;
  logic [W-1:0] data;
  logic [W-1:0] missing;
  logic         tmo;
  logic [W-1:0] cap;
  logic [W-1:0] seen_nx;
  logic         all_nx;
  logic         hs;
  logic         dup_hit;
  logic         tmo_hit;
  logic         expired;
  logic         t_clear;
  logic         t_en;

  assign cap     = lane_vld & ~seen & {W{state != ST_PRESENT}};
  assign seen_nx = seen | cap;
  assign all_nx  = &seen_nx;
  assign hs      = (state == ST_PRESENT) && out_rdy;
  assign dup_hit = (state == ST_PRESENT) ? |lane_vld
                                         : |(lane_vld & seen);

  assign t_clear = ((state != ST_COLLECT) &&
                    (state_nx == ST_COLLECT)) || hs;
  assign t_en    = (state == ST_COLLECT);

  assign out_vld     = (state == ST_PRESENT);
  assign busy        = (state != ST_IDLE);
  assign out_data    = data;
  assign out_missing = missing;
  assign out_timeout = tmo;

  lane_collector_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (t_clear),
    .enable  (t_en),
    .expired (expired)
  );

  // next state; completion beats timeout
  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (|cap) begin
          state_nx = all_nx ? ST_PRESENT : ST_COLLECT;
        end
      end
      (state == ST_COLLECT): begin
        if (all_nx) begin
          state_nx = ST_PRESENT;
        end else if (expired) begin
          state_nx = ST_PRESENT;
          tmo_hit  = 1'b1;
        end
      end
      (state == ST_PRESENT): begin
        if (out_rdy) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // state and sticky duplicate flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      err_dup <= 1'b0;
    end else begin
      state <= state_nx;
      if (dup_hit) err_dup <= 1'b1;
    end
  end

  // word assembly, cleared on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen    <= '0;
      data    <= '0;
      missing <= '0;
      tmo     <= 1'b0;
    end else if (hs) begin
      seen    <= '0;
      data    <= '0;
      missing <= '0;
      tmo     <= 1'b0;
    end else begin
      seen <= seen_nx;
      data <= data | (cap & lane_bit);
      if (tmo_hit) begin
        missing <= ~seen_nx;
        tmo     <= 1'b1;
      end
    end
  end

endmodule
